// File: rtl/axi_dw_rd_tracker_sched_pkg.sv
// rtl/axi_dw_rd_tracker_sched_pkg.sv - tracker types and sizing helper; beats field exists only with AXI_DW_SCHED_LEN_CHECK_EN
package axi_dw_sched_pkg;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int MAX_READS = 4;
  localparam int ID_WIDTH  = 4;
  localparam int IDX_WIDTH = ceil_log2(MAX_READS);

  typedef logic [IDX_WIDTH-1:0] idx_t;

  // seq counts how many older same-ID reads must retire before this one
  typedef struct packed {
    logic                busy;
    logic [ID_WIDTH-1:0] id;
    idx_t                seq;
`ifdef AXI_DW_SCHED_LEN_CHECK_EN
    logic [7:0]          beats;
`endif
  } tracker_t;

endpackage

// File: rtl/axi_dw_rd_tracker_sched_if.sv
// rtl/axi_dw_rd_tracker_sched_if.sv - AR/R scheduling signals between upsizer paths and the tracker scheduler
interface axi_dw_rd_tracker_sched_if #(
  parameter int MaxReads = axi_dw_sched_pkg::MAX_READS,
  parameter int IdWidth  = axi_dw_sched_pkg::ID_WIDTH,
  parameter int IdxWidth = axi_dw_sched_pkg::ceil_log2(MaxReads)
);
  logic                ar_valid_i;
  logic                ar_ready_o;
  logic [IdWidth-1:0]  ar_id_i;
  logic [7:0]          ar_len_i;
  logic [IdxWidth-1:0] alloc_idx_o;
  logic                r_valid_i;
  logic                r_ready_i;
  logic [IdWidth-1:0]  r_id_i;
  logic                r_last_i;
  logic                r_sel_valid_o;
  logic [IdxWidth-1:0] r_sel_idx_o;
  logic                r_err_o;
  logic [MaxReads-1:0] busy_o;
  logic                idle_o;

  modport slave (
    input  ar_valid_i, ar_id_i, ar_len_i, r_valid_i, r_ready_i, r_id_i, r_last_i,
    output ar_ready_o, alloc_idx_o, r_sel_valid_o, r_sel_idx_o, r_err_o, busy_o, idle_o
  );

  modport master (
    output ar_valid_i, ar_id_i, ar_len_i, r_valid_i, r_ready_i, r_id_i, r_last_i,
    input  ar_ready_o, alloc_idx_o, r_sel_valid_o, r_sel_idx_o, r_err_o, busy_o, idle_o
  );
endinterface

// File: rtl/axi_dw_rd_tracker_sched_free_find.sv
// rtl/axi_dw_rd_tracker_sched_free_find.sv - lowest-index free tracker finder
module axi_dw_sched_free_find #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] busy,
  output logic [W-1:0] idx,
  output logic         any_free
);
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = W'(i);
        any_free = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_dw_rd_tracker_sched.sv
// rtl/axi_dw_rd_tracker_sched.sv - read tracker allocation and same-ID ordered R selection; AXI_DW_SCHED_LEN_CHECK_EN adds beat counting
module axi_dw_rd_tracker_sched
  import axi_dw_sched_pkg::*;
#(
  parameter int MaxReads = MAX_READS,
  parameter int IdWidth  = ID_WIDTH,
  parameter int IdxWidth = ceil_log2(MaxReads)
) (
  input logic                     clk_i,
  input logic                     rst_i,
  axi_dw_rd_tracker_sched_if.slave bus
);
  typedef logic [IdWidth-1:0] id_t;

  tracker_t            trk [MaxReads];
  logic [MaxReads-1:0] busy;
  logic [IdxWidth-1:0] free_idx, sel_idx, new_seq;
  logic                any_free, sel_valid, ar_hs, r_hs, release_hit, len_err, err_q;
  id_t                 ar_id, r_id;

  assign ar_id = bus.ar_id_i;
  assign r_id  = bus.r_id_i;

  always_comb begin
    busy = '0;
    for (int i = 0; i < MaxReads; i++) busy[i] = trk[i].busy;
  end

  axi_dw_sched_free_find #(.N(MaxReads), .W(IdxWidth)) u_free_find (
    .busy     (busy),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign ar_hs = bus.ar_valid_i & any_free;
  assign r_hs  = bus.r_valid_i & bus.r_ready_i;

  // Only the oldest outstanding read of an ID carries seq == 0
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = MaxReads - 1; i >= 0; i--) begin
      if (trk[i].busy && trk[i].id == r_id && trk[i].seq == '0) begin
        sel_valid = 1'b1;
        sel_idx   = IdxWidth'(i);
      end
    end
  end

  assign release_hit = r_hs & sel_valid & bus.r_last_i;

`ifdef AXI_DW_SCHED_LEN_CHECK_EN
  assign len_err = r_hs & sel_valid &
                   (bus.r_last_i ? (trk[sel_idx].beats != 8'd0) : (trk[sel_idx].beats == 8'd0));
`else
  logic [7:0] unused_ar_len;
  assign unused_ar_len = bus.ar_len_i;
  assign len_err       = 1'b0;
`endif

  // A same-ID tracker retiring this cycle no longer counts as older
  always_comb begin
    new_seq = '0;
    for (int i = 0; i < MaxReads; i++) begin
      if (trk[i].busy && trk[i].id == ar_id && !(release_hit && sel_idx == IdxWidth'(i)))
        new_seq = new_seq + IdxWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxReads; i++) trk[i] <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= r_hs & (~sel_valid | len_err);
      for (int i = 0; i < MaxReads; i++) begin
        if (release_hit && sel_idx == IdxWidth'(i)) begin
          trk[i] <= '0;
        end else if (release_hit && trk[i].busy && trk[i].id == r_id) begin
          trk[i].seq <= trk[i].seq - idx_t'(1);
        end
`ifdef AXI_DW_SCHED_LEN_CHECK_EN
        if (r_hs && sel_valid && !bus.r_last_i && !len_err && sel_idx == IdxWidth'(i))
          trk[i].beats <= trk[i].beats - 8'd1;
`endif
        if (ar_hs && free_idx == IdxWidth'(i)) begin
          trk[i].busy  <= 1'b1;
          trk[i].id    <= ar_id;
          trk[i].seq   <= new_seq;
`ifdef AXI_DW_SCHED_LEN_CHECK_EN
          trk[i].beats <= bus.ar_len_i;
`endif
        end
      end
    end
  end

  assign bus.ar_ready_o    = any_free;
  assign bus.alloc_idx_o   = free_idx;
  assign bus.r_sel_valid_o = sel_valid;
  assign bus.r_sel_idx_o   = sel_idx;
  assign bus.r_err_o       = err_q;
  assign bus.busy_o        = busy;
  assign bus.idle_o        = ~|busy;
endmodule

// File: tb/tb_axi_dw_rd_tracker_sched.sv
// tb/tb_axi_dw_rd_tracker_sched.sv - directed and random checks of the read-tracker scheduler against a per-ID queue model
module tb_axi_dw_rd_tracker_sched;
  localparam int NR = 4;
`ifdef AXI_DW_SCHED_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic clk, rst;
  int   tests, fails;

  axi_dw_rd_tracker_sched_if #(.MaxReads(NR), .IdWidth(4), .IdxWidth(2)) bus ();
  axi_dw_rd_tracker_sched dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: outstanding trackers per ID kept as FIFOs of tracker indices
  bit m_busy [NR];
  int m_id   [NR];
  int m_rem  [NR];
  int m_q    [16][$];
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 0; m_id[i] = 0; m_rem[i] = 0;
    end
    for (int j = 0; j < 16; j++) m_q[j].delete();
    m_err = 0;
  endtask

  task automatic drive_idle();
    bus.ar_valid_i = 0; bus.ar_id_i = '0; bus.ar_len_i = '0;
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_id_i = '0; bus.r_last_i = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic cycle(input bit av, input int aid, input int alen,
                       input bit rv, input bit rr, input int rid, input bit rl);
    int  free, t, exp_busy;
    bit  sv, mism, new_err;
    bus.ar_valid_i = av; bus.ar_id_i = 4'(aid); bus.ar_len_i = 8'(alen);
    bus.r_valid_i = rv; bus.r_ready_i = rr; bus.r_id_i = 4'(rid); bus.r_last_i = rl;
    @(negedge clk);
    free = -1;
    exp_busy = 0;
    for (int i = 0; i < NR; i++) begin
      if (!m_busy[i] && free < 0) free = i;
      if (m_busy[i]) exp_busy |= (1 << i);
    end
    chk("ar_ready", 32'(bus.ar_ready_o), int'(free >= 0));
    if (free >= 0) chk("alloc_idx", 32'(bus.alloc_idx_o), free);
    sv = m_q[rid].size() > 0;
    chk("r_sel_valid", 32'(bus.r_sel_valid_o), int'(sv));
    if (sv) chk("r_sel_idx", 32'(bus.r_sel_idx_o), m_q[rid][0]);
    chk("busy", 32'(bus.busy_o), exp_busy);
    chk("idle", 32'(bus.idle_o), int'(exp_busy == 0));
    chk("r_err", 32'(bus.r_err_o), int'(m_err));
    new_err = 0;
    if (rv && rr) begin
      if (!sv) new_err = 1;
      else begin
        t = m_q[rid][0];
        mism = LEN_CHK && (rl ? (m_rem[t] != 0) : (m_rem[t] == 0));
        new_err = mism;
        if (rl) begin
          void'(m_q[rid].pop_front());
          m_busy[t] = 0;
        end else if (!mism) m_rem[t]--;
      end
    end
    if (av && free >= 0) begin
      m_busy[free] = 1; m_id[free] = aid; m_rem[free] = alen;
      m_q[aid].push_back(free);
    end
    m_err = new_err;
    @(posedge clk); #1;
  endtask

  task automatic ar(input int id, input int len);
    cycle(1, id, len, 0, 0, 0, 0);
  endtask

  task automatic rb(input int id, input bit last);
    cycle(0, 0, 0, 1, 1, id, last);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k, rid;
    tests = 0; fails = 0;
    rst = 1;
    drive_idle();
    model_clear();
    do_reset();
    idle();

    // Fill, full, free one, refill into the freed slot
    ar(1, 0); ar(2, 0); ar(3, 0); ar(4, 0);
    idle();
    rb(3, 1);
    ar(6, 0);
    rb(1, 1); rb(2, 1); rb(4, 1); rb(6, 1);
    idle();

    // Same-ID ordering
    ar(5, 1); ar(5, 0);
    rb(5, 0); rb(5, 1); rb(5, 1);
    idle();

    // Release and AR in the same cycle while full
    ar(1, 0); ar(2, 0); ar(3, 0); ar(4, 0);
    cycle(1, 7, 0, 1, 1, 2, 1);
    ar(7, 0);
    rb(1, 1); rb(7, 1); rb(3, 1); rb(4, 1);
    idle();

    // Same-ID overlap with release
    ar(2, 0);
    cycle(1, 2, 0, 1, 1, 2, 1);
    rb(2, 1);
    idle();

    // Unmatched R beat, then length mismatch
    rb(9, 0);
    idle(); idle();
    ar(3, 2);
    rb(3, 0); rb(3, 1);
    idle(); idle();

    // Mid-operation reset
    ar(1, 0); ar(2, 0); ar(3, 0);
    do_reset();
    idle();
    rb(1, 1);
    idle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(NR - 1));
      rid = ($urandom_range(3) != 0 && m_busy[k]) ? m_id[k] : int'($urandom_range(15));
      cycle($urandom_range(1), int'($urandom_range(3)), int'($urandom_range(2)),
            $urandom_range(1), $urandom_range(3) != 0, rid, $urandom_range(1));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_dw_rd_tracker_sched.md
# axi_dw_rd_tracker_sched

Read-transaction scheduler for the AXI data-width upsizer. It owns the pool of `MaxReads` read trackers. On each slave-port AR handshake it allocates a free tracker. For each wide R beat from the master port it selects the tracker that the beat belongs to, preserving AXI same-ID ordering. It sits between the upsizer's AR path, its R demultiplexer and the tracker datapath.

## Interface
- `MaxReads`, 4: number of read trackers; ≥1.
- `IdWidth`, 4: AXI ID width.
- `IdxWidth`, `$clog2(MaxReads)` (min 1): tracker index width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `ar_valid_i` in 1: slave-port AR valid.
- `ar_ready_o` out 1: AR accepted; high iff at least one tracker is free.
- `ar_id_i` in IdWidth: AR ID.
- `ar_len_i` in 8: expected number of wide R beats minus one.
- `alloc_idx_o` out IdxWidth: tracker granted on this AR handshake; lowest free index.
- `r_valid_i` in 1: wide R beat valid.
- `r_ready_i` in 1: downstream has consumed the beat; handshake = `r_valid_i & r_ready_i`.
- `r_id_i` in IdWidth: R beat ID.
- `r_last_i` in 1: R beat last flag.
- `r_sel_valid_o` out 1: a matching tracker exists.
- `r_sel_idx_o` out IdxWidth: selected tracker.
- `r_err_o` out 1: protocol error pulse; registered, one cycle.
- `busy_o` out MaxReads: tracker-busy vector.
- `idle_o` out 1: all trackers free.

## Operation
- Per-tracker state: `busy`, `id`, `seq` (IdxWidth), and, when configured, `beats` (8 bit).
- Allocation on AR handshake:
  - Chosen tracker is the lowest index with `busy=0`, computed from registered `busy`.
  - A tracker released in the same cycle is not reusable until the next cycle.
  - Set `busy=1`, `id=ar_id_i`, `beats=ar_len_i`.
  - Set `seq` = number of busy trackers with the same ID, excluding one that is releasing this cycle.
- Selection is combinational: the unique busy tracker with `id==r_id_i` and `seq==0`. `r_sel_valid_o=0` if none exists.
- Beat handshake on the selected tracker:
  - If `r_last_i`: release it (`busy=0`) and decrement `seq` of every other busy tracker with the same ID.
  - Otherwise: decrement `beats`.
- `r_err_o` is asserted the cycle after either event:
  - an R handshake with no matching tracker, or
  - a length mismatch (configured only): `r_last_i` with `beats≠0`, or non-last with `beats==0`.
- On error the tracker is still released on `r_last_i`. Otherwise the state is unchanged.
- Simultaneous AR and R for the same ID in the same cycle: the new `seq` accounts for the release, so the ordering stays strict.

## Timing
- Reset values: all `busy=0`, `seq=0`, `beats=0`; `ar_ready_o=1`, `idle_o=1`, `busy_o=0`, `r_err_o=0`, `r_sel_valid_o=0`; `alloc_idx_o=0`.
- `ar_ready_o` depends only on registered state. It does not depend on `ar_valid_i`.
- Allocation takes effect at the next edge: `busy_o` bit rises 1 cycle after the AR handshake.
- Select path: `r_id_i` → `r_sel_*` is 0-latency combinational. Release takes effect at the next edge.
- Full: all busy → `ar_ready_o=0`. It returns to 1 the cycle after a last-beat handshake.
- Single tracker (`MaxReads=1`): a same-cycle release and AR is not accepted. Throughput is one read per 2+ cycles.
- Reset mid-operation drops all trackers. Subsequent R beats for those IDs raise `r_err_o`.

## Configuration
- `AXI_DW_SCHED_LEN_CHECK_EN`
  - Defined: per-tracker `beats` counters exist and length mismatch raises `r_err_o`.
  - Undefined: no counters, `ar_len_i` is ignored, release is on `r_last_i` only, and `r_err_o` flags the no-match case only.

## Structure
- `axi_dw_sched_pkg`: `tracker_t` struct (`busy`, `id`, `seq`, `beats`), `idx_t`, and a `ceil_log2` helper.
- Sub-module `axi_dw_sched_free_find`: lowest-free-index finder. Outputs are `idx` and `any_free`.
- The same-ID counting and selection stay inline.

## Test plan
- Reset, then 4 ARs with IDs 1,2,3,4 and len 0 → `alloc_idx_o`=0,1,2,3. After the 4th, `ar_ready_o=0`. Last beat for ID 3 → `ar_ready_o=1` next cycle and the next AR gets idx 2.
- Same-ID ordering: ARs with ID 5 len 1 (idx 0) and ID 5 len 0 (idx 1).
  - R beats ID 5 select idx 0, idx 0 (last), then idx 1.
  - `seq` of idx 1 goes 1→0 after the first release.
- Simultaneous events: trackers 0–3 busy; same cycle as a last beat on idx 1, AR ID 7 → AR not accepted (`ar_ready_o=0`). Accepted the next cycle with idx 1.
- Same-ID overlap: idx 0 busy with ID 2; same cycle as its last beat, AR ID 2 → new tracker gets `seq=0`. It is selected immediately for the following beat.
- Errors:
  - R handshake ID 9 with no tracker → `r_err_o` pulses one cycle, state unchanged.
  - With `AXI_DW_SCHED_LEN_CHECK_EN`: AR len 2, then `r_last_i` on the 2nd beat → `r_err_o`=1 and the tracker is released.
- Mid-operation reset: assert `rst_i` for one cycle with 3 trackers busy → next cycle `busy_o=0`, `idle_o=1`, `ar_ready_o=1`.
